sm_adder_sweep_checker: RTL and testbench

//  Self-test stage wrapped around the 4-bit sign-magnitude ROM adder.
//  - Drives a_o/b_o through all 256 operand pairs.
//  - Checks the ROM's 5-bit sum against a combinational golden model.
//  - Reports pass/fail, the error count and the first failing address.
//  - Used at bring-up and in bench regression to qualify ROM contents.

---
 rtl/sm_adder_sweep_checker.sv | 155 +++++++++++++++
 tb/tb_sm_adder_sweep_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sm_adder_sweep_checker.sv
// Self-test sweep around the 4-bit sign-magnitude ROM adder.
// Walks all 256 {a,b} operand pairs and compares the returned 5-bit sums
// against a built-in golden model. It reports pass/fail, a saturating error
// count and the first failing address.
module sm_adder_sweep_checker #(
  parameter int ROM_LATENCY   = 1,
  parameter int ERR_CNT_WIDTH = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  output logic [3:0]               a_o,
  output logic [3:0]               b_o,
  input  logic [4:0]               sum_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic                     first_err_valid_o,
  output logic [7:0]               first_err_addr_o
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0]               DRAIN_LAST = 3'(ROM_LATENCY - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = '1;

  state_t                         r_state;
  logic [7:0]                     r_ab;        // operand pair on the bus, doubles as sweep address
  logic [2:0]                     r_dcnt;
  logic                           r_busy, r_done, r_pass;
  logic [ERR_CNT_WIDTH-1:0]       r_err;
  logic                           r_fv;
  logic [7:0]                     r_fa;
  logic [ROM_LATENCY-1:0]         r_vld_pipe;
  logic [ROM_LATENCY-1:0][7:0]    r_addr_pipe;

  logic       w_start, w_issue_vld, w_mis;
  logic [7:0] w_issue_addr, w_chk_addr;

  // Reference sum: {sign, mag[3:0]}; a zero magnitude never carries a sign.
  function automatic logic [4:0] golden(input logic [7:0] ab);
    logic       sa, sb, sgn;
    logic [3:0] ma, mb, mag;
    sa = ab[7];
    sb = ab[3];
    ma = {1'b0, ab[6:4]};
    mb = {1'b0, ab[2:0]};
    if (sa == sb) begin
      mag = ma + mb;
      sgn = sa;
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = sa;
    end else begin
      mag = mb - ma;
      sgn = sb;
    end
    if (mag == 4'd0) sgn = 1'b0;
    return {sgn, mag};
  endfunction

  // Start is only honoured while idle or finished.
  assign w_start      = start_i && (r_state == S_IDLE || r_state == S_DONE);
  // Next operand pair to present; invalid once address 255 has been issued.
  assign w_issue_vld  = w_start || (r_state == S_SWEEP && r_ab != 8'hFF);
  assign w_issue_addr = (r_state == S_SWEEP) ? r_ab + 8'd1 : 8'd0;
  assign w_chk_addr   = r_addr_pipe[ROM_LATENCY-1];
  assign w_mis        = r_vld_pipe[ROM_LATENCY-1] && (sum_i != golden(w_chk_addr));

  assign a_o               = r_ab[7:4];
  assign b_o               = r_ab[3:0];
  assign busy_o            = r_busy;
  assign done_o            = r_done;
  assign pass_o            = r_pass;
  assign err_count_o       = r_err;
  assign first_err_valid_o = r_fv;
  assign first_err_addr_o  = r_fa;

  // Sweep sequencing: IDLE -> SWEEP -> DRAIN (ROM_LATENCY cycles) -> DONE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_ab    <= 8'd0;
      r_dcnt  <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_ab <= w_issue_vld ? w_issue_addr : 8'd0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_state <= S_SWEEP;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (r_ab == 8'hFF) begin
            r_state <= S_DRAIN;
            r_dcnt  <= 3'd0;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DRAIN_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err == '0);
          end else begin
            r_dcnt <= r_dcnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Address/valid delay line aligning each issued pair with its ROM result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
    end else begin
      for (int i = ROM_LATENCY - 1; i > 0; i--) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_addr_pipe[i] <= r_addr_pipe[i-1];
      end
      r_vld_pipe[0]  <= w_issue_vld;
      r_addr_pipe[0] <= w_issue_addr;
    end
  end

  // Mismatch bookkeeping: saturating count plus first failing address.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= '0;
      r_fv  <= 1'b0;
      r_fa  <= 8'd0;
    end else if (w_start) begin
      r_err <= '0;
      r_fv  <= 1'b0;
      r_fa  <= 8'd0;
    end else if (w_mis) begin
      if (r_err != ERR_MAX) r_err <= r_err + 1'b1;
      if (!r_fv) begin
        r_fv <= 1'b1;
        r_fa <= w_chk_addr;
      end
    end
  end

endmodule

// File: tb/tb_sm_adder_sweep_checker.sv
// Bench for sm_adder_sweep_checker: three builds (L=1/W=9, L=2/W=9, L=1/W=4)
// driven by ROM models with selectable planted faults; expected run results
// are queued at start and checked by per-instance monitors on done rising.
module tb_sm_adder_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int   err;
    bit   fv;
    int   fa;
    bit   pass;
    int   t0;
    int   lat;
  } exp_t;

  exp_t q1[$], q2[$], q3[$];

  // ROM content model; mode selects planted faults.
  function automatic logic [4:0] rom(input int mode, input logic [7:0] ab);
    int va, vb, s;
    logic [4:0] r;
    va = ab[7] ? -int'(ab[6:4]) : int'(ab[6:4]);
    vb = ab[3] ? -int'(ab[2:0]) : int'(ab[2:0]);
    s  = va + vb;
    r  = (s < 0) ? {1'b1, 4'(-s)} : {1'b0, 4'(s)};
    if (mode == 1 && ab == 8'h9A) r = 5'h03;
    if (mode == 2 && (ab == 8'h80 || ab == 8'h5D)) r = 5'h10;
    if (mode == 3) r = 5'h00;
    return r;
  endfunction

  // Instance 1: L=1, combinational ROM
  int         mode1 = 0;
  logic       st1 = 1'b0;
  logic [3:0] a1, b1;
  logic [4:0] sum1;
  logic       busy1, done1, pass1, fv1;
  logic [8:0] err1;
  logic [7:0] fa1;
  assign sum1 = rom(mode1, {a1, b1});

  sm_adder_sweep_checker #(.ROM_LATENCY(1), .ERR_CNT_WIDTH(9)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st1), .a_o(a1), .b_o(b1), .sum_i(sum1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
    .first_err_valid_o(fv1), .first_err_addr_o(fa1));

  // Instance 2: L=2, one register stage in the ROM
  logic       st2 = 1'b0;
  logic [3:0] a2, b2;
  logic [4:0] sum2 = 5'd0;
  logic       busy2, done2, pass2, fv2;
  logic [8:0] err2;
  logic [7:0] fa2;
  always @(posedge clk) sum2 <= rom(0, {a2, b2});

  sm_adder_sweep_checker #(.ROM_LATENCY(2), .ERR_CNT_WIDTH(9)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st2), .a_o(a2), .b_o(b2), .sum_i(sum2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
    .first_err_valid_o(fv2), .first_err_addr_o(fa2));

  // Instance 3: 4-bit error counter, sum tied to zero
  logic       st3 = 1'b0;
  logic [3:0] a3, b3;
  logic [4:0] sum3;
  logic       busy3, done3, pass3, fv3;
  logic [3:0] err3;
  logic [7:0] fa3;
  assign sum3 = 5'd0;

  sm_adder_sweep_checker #(.ROM_LATENCY(1), .ERR_CNT_WIDTH(4)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(st3), .a_o(a3), .b_o(b3), .sum_i(sum3),
    .busy_o(busy3), .done_o(done3), .pass_o(pass3), .err_count_o(err3),
    .first_err_valid_o(fv3), .first_err_addr_o(fa3));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_res(input string nm, input exp_t e, input int err, input bit fv,
                           input int fa, input bit pass);
    chk({nm, ".err_count"}, err, e.err);
    chk({nm, ".first_valid"}, int'(fv), int'(e.fv));
    chk({nm, ".first_addr"}, fa, e.fa);
    chk({nm, ".pass"}, int'(pass), int'(e.pass));
    chk({nm, ".done_cycle"}, cyc - e.t0, e.lat);
  endtask

  task automatic unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: done with no queued expectation", nm);
  endtask

  // Monitors: pop and compare whenever an instance raises done_o.
  logic d1q = 1'b0, d2q = 1'b0, d3q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done1 && !d1q) begin
      if (q1.size() == 0) unexpected("mon1");
      else begin e = q1.pop_front(); check_res("mon1", e, int'(err1), fv1, int'(fa1), pass1); end
    end
    if (done2 && !d2q) begin
      if (q2.size() == 0) unexpected("mon2");
      else begin e = q2.pop_front(); check_res("mon2", e, int'(err2), fv2, int'(fa2), pass2); end
    end
    if (done3 && !d3q) begin
      if (q3.size() == 0) unexpected("mon3");
      else begin e = q3.pop_front(); check_res("mon3", e, int'(err3), fv3, int'(fa3), pass3); end
    end
    d1q <= done1;
    d2q <= done2;
    d3q <= done3;
  end

  // One start pulse on instance 1; checks busy length and that done arrives.
  task automatic run1(input exp_t e, input int mode);
    int nb;
    nb = 0;
    @(negedge clk);
    mode1 = mode;
    st1   = 1'b1;
    e.t0  = cyc + 1;
    q1.push_back(e);
    @(negedge clk);
    st1 = 1'b0;
    for (int i = 0; i < 1000 && !done1; i++) begin
      if (busy1) nb++;
      @(negedge clk);
    end
    chk("run1.done_seen", int'(done1), 1);
    chk("run1.busy_len", nb, 257);
  endtask

  function automatic int outs1();
    return int'({a1, b1}) + int'(busy1) + int'(done1) + int'(pass1) + int'(err1) + int'(fv1) + int'(fa1);
  endfunction

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("reset.outs1", outs1(), 0);
    chk("reset.outs2", int'({a2, b2, busy2, done2, pass2, err2, fv2, fa2}), 0);
    chk("reset.outs3", int'({a3, b3, busy3, done3, pass3, err3, fv3, fa3}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.no_start", int'({busy1, done1}), 0);

    // correct ROM, then single, negative-zero and all-zero fault sets
    run1('{0,   1'b0, 8'h00, 1'b1, 0, 257}, 0);
    run1('{1,   1'b1, 8'h9A, 1'b0, 0, 257}, 1);
    run1('{2,   1'b1, 8'h5D, 1'b0, 0, 257}, 2);
    run1('{238, 1'b1, 8'h01, 1'b0, 0, 257}, 3);

    // reset in the middle of a sweep
    @(negedge clk);
    mode1 = 0;
    st1   = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    for (int i = 0; i < 300 && {a1, b1} != 8'd100; i++) @(negedge clk);
    chk("midrst.reached_100", int'({a1, b1}), 100);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.outs", outs1(), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst.stays_idle", int'({busy1, done1, a1, b1}), 0);
    run1('{0, 1'b0, 8'h00, 1'b1, 0, 257}, 0);

    // L=2 build with start held high: back-to-back runs
    @(negedge clk);
    st2  = 1'b1;
    e    = '{0, 1'b0, 8'h00, 1'b1, cyc + 1, 258};
    q2.push_back(e);
    e.t0 = e.t0 + 259;
    q2.push_back(e);
    for (int i = 0; i < 1000 && !done2; i++) @(negedge clk);
    chk("l2.done1_seen", int'(done2), 1);
    @(negedge clk);
    chk("l2.restart_done_low", int'(done2), 0);
    chk("l2.restart_busy", int'(busy2), 1);
    chk("l2.restart_err", int'(err2), 0);
    for (int i = 0; i < 1000 && !done2; i++) @(negedge clk);
    chk("l2.done2_seen", int'(done2), 1);
    st2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("l2.holds_done", int'({done2, busy2}), 2);

    // 4-bit counter saturation
    @(negedge clk);
    st3 = 1'b1;
    q3.push_back('{15, 1'b1, 8'h01, 1'b0, cyc + 1, 257});
    @(negedge clk);
    st3 = 1'b0;
    for (int i = 0; i < 1000 && !done3; i++) @(negedge clk);
    chk("sat.done_seen", int'(done3), 1);
    repeat (2) @(negedge clk);

    chk("queues_drained", q1.size() + q2.size() + q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
